// File: rtl/cpu.sv
// 4-bit accumulator processor: switch data word, 16-entry ALU opcode set,
// condition flag Z shown on a single LED.
module cpu (
    input  logic       clock,
    input  logic       reset,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    input  logic [3:0] operation,
    input  logic       enable,
    output logic       out
);

    localparam int unsigned DW = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_ROL  = 4'hC;
    localparam logic [3:0] OP_EQ   = 4'hD;
    localparam logic [3:0] OP_ADC  = 4'hE;
    localparam logic [3:0] OP_CLR  = 4'hF;

    logic [DW-1:0] d;
    logic [DW-1:0] acc;
    logic          c;
    logic [DW-1:0] acc_nxt;
    logic          c_nxt;
    logic          z_nxt;
    logic [DW:0]   sum;

    assign d = {SW4, SW3, SW2, SW1};

    // ALU decode: next accumulator, carry and zero flag for the current opcode
    always_comb begin
        acc_nxt = acc;
        c_nxt   = c;
        z_nxt   = out;
        sum     = '0;
        case (operation)
            OP_NOP: begin
            end
            OP_LOAD: acc_nxt = d;
            OP_AND:  acc_nxt = acc & d;
            OP_OR:   acc_nxt = acc | d;
            OP_XOR:  acc_nxt = acc ^ d;
            OP_NOT:  acc_nxt = ~acc;
            OP_ADD: begin
                sum     = (DW+1)'(acc) + (DW+1)'(d);
                acc_nxt = sum[DW-1:0];
                c_nxt   = sum[DW];
            end
            OP_SUB: begin
                acc_nxt = acc - d;
                c_nxt   = (acc < d);
            end
            OP_INC: begin
                sum     = (DW+1)'(acc) + (DW+1)'(1);
                acc_nxt = sum[DW-1:0];
                c_nxt   = sum[DW];
            end
            OP_DEC: begin
                acc_nxt = acc - DW'(1);
                c_nxt   = (acc == '0);
            end
            OP_SHL: begin
                acc_nxt = {acc[DW-2:0], 1'b0};
                c_nxt   = acc[DW-1];
            end
            OP_SHR: begin
                acc_nxt = {1'b0, acc[DW-1:1]};
                c_nxt   = acc[0];
            end
            OP_ROL:  acc_nxt = {acc[DW-2:0], acc[DW-1]};
            OP_EQ: begin
            end
            OP_ADC: begin
                sum     = (DW+1)'(acc) + (DW+1)'(d) + (DW+1)'(c);
                acc_nxt = sum[DW-1:0];
                c_nxt   = sum[DW];
            end
            OP_CLR: begin
                acc_nxt = '0;
                c_nxt   = 1'b0;
            end
            default: begin
            end
        endcase
        // Z follows the result except for NOP (hold), EQ (compare) and CLR (forced)
        if (operation == OP_EQ) begin
            z_nxt = (acc == d);
        end else if (operation == OP_CLR) begin
            z_nxt = 1'b1;
        end else if (operation != OP_NOP) begin
            z_nxt = (acc_nxt == '0);
        end
    end

    // State update: synchronous reset wins, enable gates every register
    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            c   <= 1'b0;
            out <= 1'b0;
        end else if (enable) begin
            acc <= acc_nxt;
            c   <= c_nxt;
            out <= z_nxt;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed scenarios plus a random opcode stream
// compared against an arithmetic reference model of ACC, C and Z.
module tb_cpu;

    logic       clock = 1'b0;
    logic       reset;
    logic       SW1, SW2, SW3, SW4;
    logic [3:0] operation;
    logic       enable;
    logic       out;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    int m_acc = 0;
    int m_c   = 0;
    int m_z   = 0;

    cpu dut (
        .clock     (clock),
        .reset     (reset),
        .SW1       (SW1),
        .SW2       (SW2),
        .SW3       (SW3),
        .SW4       (SW4),
        .operation (operation),
        .enable    (enable),
        .out       (out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: out=%0b expected %0b (model acc=%0h c=%0d)", tag, got, exp, m_acc, m_c);
        end
    endtask

    // behavioural model of one clock edge
    task automatic model_step(input int rst, input int en, input int op, input int dv);
        int s;
        if (rst != 0) begin
            m_acc = 0; m_c = 0; m_z = 0;
        end else if (en != 0) begin
            case (op)
                0:  ;
                1:  m_acc = dv;
                2:  m_acc = m_acc & dv;
                3:  m_acc = m_acc | dv;
                4:  m_acc = m_acc ^ dv;
                5:  m_acc = 15 - m_acc;
                6:  begin s = m_acc + dv; m_c = (s > 15); m_acc = s % 16; end
                7:  begin m_c = (m_acc < dv); m_acc = (m_acc - dv + 16) % 16; end
                8:  begin s = m_acc + 1; m_c = (s > 15); m_acc = s % 16; end
                9:  begin m_c = (m_acc == 0); m_acc = (m_acc + 15) % 16; end
                10: begin m_c = (m_acc >= 8); m_acc = (m_acc * 2) % 16; end
                11: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
                12: m_acc = (m_acc * 2) % 16 + m_acc / 8;
                13: ;
                14: begin s = m_acc + dv + m_c; m_c = (s > 15); m_acc = s % 16; end
                default: begin m_acc = 0; m_c = 0; end
            endcase
            if (op == 13)      m_z = (m_acc == dv);
            else if (op == 15) m_z = 1;
            else if (op != 0)  m_z = (m_acc == 0);
        end
    endtask

    // one clock cycle: drive at negedge, sample 1ns after the rising edge;
    // want < 0 compares against the model only, otherwise also against want
    task automatic apply(input int rst, input int en, input int op, input int dv,
                         input string tag, input int want);
        logic [3:0] dd;
        @(negedge clock);
        dd        = 4'(dv);
        reset     = (rst != 0);
        enable    = (en != 0);
        operation = 4'(op);
        {SW4, SW3, SW2, SW1} = dd;
        @(posedge clock);
        #1;
        model_step(rst, en, op, dv);
        if (want >= 0) check(tag, out, (want != 0));
        else           check(tag, out, (m_z != 0));
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; operation = 4'h0;
        {SW4, SW3, SW2, SW1} = 4'h0;

        // reset beats a pending LOAD
        apply(1, 1, 1, 15, "reset", 0);
        apply(0, 1, 13, 0, "reset_acc0", 1);
        apply(0, 1, 8, 0, "reset_inc", 0);
        apply(1, 1, 1, 15, "reset2", 0);

        // hold with enable low
        for (int i = 0; i < 5; i++) apply(0, 0, 1, 10, "hold", 0);
        apply(0, 1, 13, 0, "hold_acc0", 1);
        apply(0, 1, 1, 10, "load_a", 0);
        apply(0, 1, 13, 10, "load_a_eq", 1);

        // wrap and carry
        apply(0, 1, 1, 15, "load_f", 0);
        apply(0, 1, 8, 0, "inc_wrap", 1);
        apply(0, 1, 13, 0, "inc_wrap_acc", 1);
        apply(0, 1, 14, 0, "adc_carry", 0);
        apply(0, 1, 13, 1, "adc_carry_acc", 1);

        // borrow
        apply(0, 1, 1, 5, "load_5", 0);
        apply(0, 1, 7, 5, "sub_zero", 1);
        apply(0, 1, 7, 1, "sub_borrow", 0);
        apply(0, 1, 13, 15, "sub_borrow_acc", 1);
        apply(0, 1, 14, 0, "borrow_c1", 1);

        // compare and logic
        apply(0, 1, 1, 10, "load_a2", 0);
        apply(0, 1, 13, 10, "eq_true", 1);
        apply(0, 1, 13, 3, "eq_false", 0);
        apply(0, 1, 13, 10, "eq_keeps_acc", 1);
        apply(0, 1, 4, 15, "xor_f", 0);
        apply(0, 1, 13, 5, "xor_acc", 1);
        apply(0, 1, 10, 0, "shl", 0);
        apply(0, 1, 13, 10, "shl_acc", 1);
        apply(0, 1, 14, 0, "shl_c0", 0);

        // reset in the middle of an ADD
        apply(0, 1, 1, 15, "load_f2", 0);
        apply(1, 1, 6, 3, "reset_mid", 0);
        apply(0, 1, 14, 0, "reset_mid_c", 1);
        apply(0, 1, 0, 9, "nop_holds_z", 1);
        apply(0, 1, 15, 0, "clr", 1);
        apply(0, 1, 9, 0, "dec_wrap", 0);
        apply(0, 1, 13, 15, "dec_wrap_acc", 1);

        // random opcode stream with periodic accumulator probes
        for (int i = 0; i < 600; i++) begin
            int rst, en, op, dv;
            rst = ($urandom_range(0, 39) == 0) ? 1 : 0;
            en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            op  = int'($urandom_range(0, 15));
            dv  = int'($urandom_range(0, 15));
            apply(rst, en, op, dv, "rand", -1);
            if (i % 8 == 7) apply(0, 1, 13, m_acc, "rand_probe", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
